bsg_clk_gen_tag_sequencer: RTL

Synthesizable multi-channel programming sequencer for bsg clock generators. It replaces the single-generator, simulation-only tag programming used in gateway testbenches. Per-channel oscillator, downsampler and clock-mux settings are sampled on start. It then pulses the generators' async reset and serialises the bsg_tag packets for every enabled channel, one bit per cycle, before driving the mux selects and raising done. It sits in the gateway chip on the tag clock, driving the ASIC's tag pins and clock-gen select pins.

---
 rtl/bsg_clk_gen_tag_sequencer.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bsg_clk_gen_tag_sequencer.sv
// bsg_clk_gen_tag_sequencer
// Programs a bank of bsg clock generators over the bsg_tag serial chain:
// pulses the generators' async reset, streams five tag packets per channel
// MSB first with idle gaps, then drives the clock-mux selects and raises done.
// Optional build macro BSG_CLK_GEN_SEQ_SKIP_EN adds channel_mask_i so that
// masked-off channels are neither programmed nor selected.
module bsg_clk_gen_tag_sequencer #(
  parameter int num_clk_gens_p  = 2,
  parameter int osc_width_p     = 5,
  parameter int ds_width_p      = 8,
  parameter int tag_els_p       = 4,
  parameter int tag_node_base_p = 0,
  parameter int max_payload_p   = 16,
  parameter int reset_cycles_p  = 8,
  parameter int gap_cycles_p    = 4
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  start_i,
`ifdef BSG_CLK_GEN_SEQ_SKIP_EN
  input  logic [num_clk_gens_p-1:0]             channel_mask_i,
`endif
  input  logic [num_clk_gens_p*osc_width_p-1:0] osc_vals_i,
  input  logic [num_clk_gens_p*ds_width_p-1:0]  ds_vals_i,
  input  logic [num_clk_gens_p*2-1:0]           mux_vals_i,
  output logic                                  tag_en_o,
  output logic                                  tag_data_o,
  output logic                                  clk_gen_async_reset_o,
  output logic [num_clk_gens_p*2-1:0]           clk_gen_sel_o,
  output logic                                  busy_o,
  output logic                                  done_o
);

  localparam int ID_W      = $clog2(tag_els_p);
  localparam int LEN_W     = $clog2(max_payload_p + 1);
  localparam int PR        = 2 + ID_W + LEN_W;
  localparam int SH_W      = PR + max_payload_p;
  localparam int OSC_LEN   = PR + osc_width_p;
  localparam int DS_LEN    = PR + ds_width_p + 1;
  localparam int CNT_MAX_A = (SH_W > reset_cycles_p) ? SH_W : reset_cycles_p;
  localparam int CNT_MAX   = (CNT_MAX_A > gap_cycles_p) ? CNT_MAX_A : gap_cycles_p;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int CH_W      = (num_clk_gens_p > 1) ? $clog2(num_clk_gens_p) : 1;
  localparam int SEL_W     = num_clk_gens_p * 2;

  // A payload wider than the tag length field can describe is unusable.
  if (osc_width_p > max_payload_p || ds_width_p + 1 > max_payload_p) begin : g_payload_too_wide
    $error("bsg_clk_gen_tag_sequencer: payload width exceeds max_payload_p");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_PKT, S_GAP, S_SEL, S_DONE
  } state_e;

  state_e                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [CH_W-1:0]                   ch_q, ch_d;
  logic [2:0]                        pkt_q, pkt_d;
  logic [SH_W-1:0]                   shift_q, shift_d;
  logic [num_clk_gens_p*osc_width_p-1:0] osc_q, osc_d;
  logic [num_clk_gens_p*ds_width_p-1:0]  ds_q, ds_d;
  logic [SEL_W-1:0]                  mux_q, mux_d;
  logic                              tag_en_q, tag_en_d;
  logic                              tag_data_q, tag_data_d;
  logic                              async_reset_q, async_reset_d;
  logic [SEL_W-1:0]                  sel_q, sel_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic [num_clk_gens_p-1:0]         chan_en;
  logic [SEL_W-1:0]                  sel_masked;
  logic                              nxt_found;
  logic [CH_W-1:0]                   nxt_ch;
  logic                              load_pkt;
  int                                search_from;

`ifdef BSG_CLK_GEN_SEQ_SKIP_EN
  logic [num_clk_gens_p-1:0]         mask_q, mask_d;
  assign chan_en = mask_q;
`else
  assign chan_en = '1;
`endif

  // Builds a left-justified packet: start bit, node id, data_not_reset, len, payload.
  function automatic logic [SH_W-1:0] build_pkt(input logic [CH_W-1:0] ch,
                                                input logic [2:0] pkt,
                                                input logic [osc_width_p-1:0] osc,
                                                input logic [ds_width_p-1:0] ds);
    int                       node;
    logic                     dnr;
    logic [LEN_W-1:0]         len;
    logic [max_payload_p-1:0] pay;
    node = tag_node_base_p + 2 * int'(ch) + ((pkt == 3'd0 || pkt == 3'd2) ? 0 : 1);
    case (pkt)
      3'd2: begin
        dnr = 1'b1;
        len = LEN_W'(osc_width_p);
        pay = max_payload_p'(osc) << (max_payload_p - osc_width_p);
      end
      3'd3: begin
        dnr = 1'b1;
        len = LEN_W'(ds_width_p + 1);
        pay = max_payload_p'({ds, 1'b1}) << (max_payload_p - ds_width_p - 1);
      end
      3'd4: begin
        dnr = 1'b1;
        len = LEN_W'(ds_width_p + 1);
        pay = max_payload_p'({ds, 1'b0}) << (max_payload_p - ds_width_p - 1);
      end
      default: begin
        dnr = 1'b0;
        len = '0;
        pay = '0;
      end
    endcase
    return {1'b1, ID_W'(node), dnr, len, pay};
  endfunction

  // Total serial bits of a given packet slot.
  function automatic logic [CNT_W-1:0] pkt_len(input logic [2:0] pkt);
    case (pkt)
      3'd0, 3'd1: return CNT_W'(PR);
      3'd2:       return CNT_W'(OSC_LEN);
      default:    return CNT_W'(DS_LEN);
    endcase
  endfunction

  // Finds the next enabled channel: from 0 when leaving reset, else after the current one.
  always_comb begin
    search_from = (state_q == S_RESET) ? 0 : int'(ch_q) + 1;
    nxt_found   = 1'b0;
    nxt_ch      = '0;
    for (int i = num_clk_gens_p - 1; i >= 0; i--) begin
      if (i >= search_from && chan_en[i]) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(i);
      end
    end
  end

  // Final mux selects, with disabled channels forced to zero.
  always_comb begin
    sel_masked = '0;
    for (int c = 0; c < num_clk_gens_p; c++) begin
      sel_masked[2*c +: 2] = chan_en[c] ? mux_q[2*c +: 2] : 2'b00;
    end
  end

  // Sequencer next state, packet loading, and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    pkt_d    = pkt_q;
    shift_d  = shift_q;
    osc_d    = osc_q;
    ds_d     = ds_q;
    mux_d    = mux_q;
`ifdef BSG_CLK_GEN_SEQ_SKIP_EN
    mask_d   = mask_q;
`endif
    load_pkt = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_RESET;
          cnt_d   = '0;
          osc_d   = osc_vals_i;
          ds_d    = ds_vals_i;
          mux_d   = mux_vals_i;
`ifdef BSG_CLK_GEN_SEQ_SKIP_EN
          mask_d  = channel_mask_i;
`endif
        end
      end
      S_RESET: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(reset_cycles_p - 1)) begin
          cnt_d = '0;
          if (nxt_found) begin
            state_d  = S_PKT;
            ch_d     = nxt_ch;
            pkt_d    = '0;
            load_pkt = 1'b1;
          end else begin
            state_d = S_SEL;
          end
        end
      end
      S_PKT: begin
        cnt_d   = cnt_q + 1'b1;
        shift_d = shift_q << 1;
        if (cnt_q == pkt_len(pkt_q) - 1'b1) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(gap_cycles_p - 1)) begin
          cnt_d = '0;
          if (pkt_q != 3'd4) begin
            state_d  = S_PKT;
            pkt_d    = pkt_q + 1'b1;
            load_pkt = 1'b1;
          end else if (nxt_found) begin
            state_d  = S_PKT;
            ch_d     = nxt_ch;
            pkt_d    = '0;
            load_pkt = 1'b1;
          end else begin
            state_d = S_SEL;
          end
        end
      end
      S_SEL:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (load_pkt) begin
      shift_d = build_pkt(ch_d, pkt_d, osc_q[ch_d*osc_width_p +: osc_width_p],
                          ds_q[ch_d*ds_width_p +: ds_width_p]);
    end

    tag_en_d      = (state_d == S_PKT) || (state_d == S_GAP);
    tag_data_d    = (state_d == S_PKT) && shift_d[SH_W-1];
    async_reset_d = (state_d == S_RESET);
    busy_d        = (state_d == S_RESET) || (state_d == S_PKT) ||
                    (state_d == S_GAP)   || (state_d == S_SEL);
    done_d        = (state_d == S_DONE);
    sel_d         = ((state_d == S_SEL) || (state_d == S_DONE)) ? sel_masked : '0;
  end

  // State, latched settings and registered outputs; reset clears everything.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ch_q          <= '0;
      pkt_q         <= '0;
      shift_q       <= '0;
      osc_q         <= '0;
      ds_q          <= '0;
      mux_q         <= '0;
`ifdef BSG_CLK_GEN_SEQ_SKIP_EN
      mask_q        <= '0;
`endif
      tag_en_q      <= 1'b0;
      tag_data_q    <= 1'b0;
      async_reset_q <= 1'b0;
      sel_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ch_q          <= ch_d;
      pkt_q         <= pkt_d;
      shift_q       <= shift_d;
      osc_q         <= osc_d;
      ds_q          <= ds_d;
      mux_q         <= mux_d;
`ifdef BSG_CLK_GEN_SEQ_SKIP_EN
      mask_q        <= mask_d;
`endif
      tag_en_q      <= tag_en_d;
      tag_data_q    <= tag_data_d;
      async_reset_q <= async_reset_d;
      sel_q         <= sel_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign tag_en_o              = tag_en_q;
  assign tag_data_o            = tag_data_q;
  assign clk_gen_async_reset_o = async_reset_q;
  assign clk_gen_sel_o         = sel_q;
  assign busy_o                = busy_q;
  assign done_o                = done_q;

endmodule
